// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t      : sequencer state encodings (BOOT / RUN / MULTI)
//   DEF_REG_AW   : default register-address width of the 16-bit core
//   R0_IDX       : index of r0, which is hardwired to zero and never a hazard source
//   SEQ_CNT_W    : width of the shared BOOT/MULTI down-counter
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_MULTI = 2'd2
  } state_t;

  localparam int DEF_REG_AW = 3;
  localparam int R0_IDX     = 0;
  localparam int SEQ_CNT_W  = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_event_counter.sv
// Saturating event counter.
//   clk   : clock
//   rst   : synchronous active-low reset, clears count
//   inc   : count this cycle
//   count : number of cycles inc was high since reset, holds at all-ones
module sat_event_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst)                     count <= '0;
    else if (inc && count != '1)  count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 16-bit 5-stage core.
// Holds fetch idle after reset, resolves load-use and taken-branch hazards,
// freezes the front end during multi-cycle execute ops, and counts stall/flush
// cycles for debug.
//   clk, rst            : clock, synchronous active-low reset
//   rs1_d, rs2_d        : source regs of the instruction in decode
//   rd_e, mem_read_e    : dest reg / load flag of the instruction in execute
//   pc_select_e         : taken branch resolved in execute
//   mul_start_e         : multi-cycle op entered execute this cycle
//   imem_ready          : instruction memory data valid
//   stall_f/d/e         : hold PC, F->D, D->E registers
//   flush_d/e           : bubble into D, E registers
//   busy                : sequencer not in RUN
//   stall_cnt/flush_cnt : saturating counts of stall_f / flush_e cycles
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = DEF_REG_AW,
  parameter int BOOT_CYCLES = 4,
  parameter int MUL_CYCLES  = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              mem_read_e,
  input  logic              pc_select_e,
  input  logic              mul_start_e,
  input  logic              imem_ready,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [SEQ_CNT_W-1:0] BOOT_LOAD = SEQ_CNT_W'(BOOT_CYCLES - 1);
  // The start cycle is spent in RUN, so MULTI lasts MUL_CYCLES-1 cycles.
  localparam logic [SEQ_CNT_W-1:0] MUL_LOAD  = SEQ_CNT_W'(MUL_CYCLES - 2);

  state_t               state, state_n;
  logic [SEQ_CNT_W-1:0] cnt, cnt_n;
  logic                 load_use;

  assign load_use = mem_read_e && (rd_e != REG_AW'(R0_IDX)) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_BOOT;
      cnt   <= BOOT_LOAD;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = ST_BOOT;
    cnt_n   = cnt;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    busy    = 1'b0;
    case (state)
      ST_BOOT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
        busy    = 1'b1;
        if (cnt == '0) begin
          state_n = ST_RUN;
        end else begin
          state_n = ST_BOOT;
          cnt_n   = cnt - 1'b1;
        end
      end
      ST_RUN: begin
        state_n = ST_RUN;
        if (pc_select_e) begin
          // Taken branch kills wrong-path D/E and wins over every stall.
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (mul_start_e) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          state_n = ST_MULTI;
          cnt_n   = MUL_LOAD;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end else if (!imem_ready) begin
          stall_f = 1'b1;
          flush_d = 1'b1;
        end
      end
      ST_MULTI: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        busy    = 1'b1;
        if (cnt == '0) begin
          state_n = ST_RUN;
        end else begin
          state_n = ST_MULTI;
          cnt_n   = cnt - 1'b1;
        end
      end
      default: begin
        // Illegal encoding: behave like BOOT and restart the boot hold.
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
        busy    = 1'b1;
        state_n = ST_BOOT;
        cnt_n   = BOOT_LOAD;
      end
    endcase
  end

  sat_event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_f),
    .count (stall_cnt)
  );

  sat_event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_e),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share all inputs:
// u_dut with 16-bit counters and u_sat with 4-bit counters for saturation.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic       mr;
    logic       ps;
    logic       ms;
    logic       ir;
    logic       chk;
    logic [5:0] exp; // {stall_f, stall_d, stall_e, flush_d, flush_e, busy}
  } vec_t;

  localparam logic [5:0] C_BOOT  = 6'b110111;
  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_LU    = 6'b110010;
  localparam logic [5:0] C_BR    = 6'b000110;
  localparam logic [5:0] C_IMEM  = 6'b100100;
  localparam logic [5:0] C_MSTRT = 6'b111000;
  localparam logic [5:0] C_MULTI = 6'b111001;
  localparam int NV = 46;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] rs1_d = '0, rs2_d = '0, rd_e = '0;
  logic mem_read_e = 1'b0, pc_select_e = 1'b0, mul_start_e = 1'b0, imem_ready = 1'b1;

  logic stall_f, stall_d, stall_e, flush_d, flush_e, busy;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_stall_f, s_stall_d, s_stall_e, s_flush_d, s_flush_e, s_busy;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  int pass_cnt = 0;
  int total    = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  vec_t v [NV];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(3), .BOOT_CYCLES(4), .MUL_CYCLES(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
    .mem_read_e(mem_read_e), .pc_select_e(pc_select_e), .mul_start_e(mul_start_e),
    .imem_ready(imem_ready), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .busy(busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.REG_AW(3), .BOOT_CYCLES(4), .MUL_CYCLES(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
    .mem_read_e(mem_read_e), .pc_select_e(pc_select_e), .mul_start_e(mul_start_e),
    .imem_ready(imem_ready), .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e),
    .flush_d(s_flush_d), .flush_e(s_flush_e), .busy(s_busy),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  function automatic vec_t mk(logic r, logic [2:0] a, logic [2:0] b, logic [2:0] d,
                              logic mr, logic ps, logic ms, logic ir, logic chk,
                              logic [5:0] e);
    vec_t t;
    t.rst = r; t.rs1 = a; t.rs2 = b; t.rd = d; t.mr = mr; t.ps = ps;
    t.ms = ms; t.ir = ir; t.chk = chk; t.exp = e;
    return t;
  endfunction

  task automatic check(string name, int act, int req);
    total++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic drive(vec_t t);
    rst = t.rst; rs1_d = t.rs1; rs2_d = t.rs2; rd_e = t.rd;
    mem_read_e = t.mr; pc_select_e = t.ps; mul_start_e = t.ms; imem_ready = t.ir;
  endtask

  // Compare counters against the running model, then account for this cycle.
  task automatic check_counters(string tag, logic r, logic [5:0] e);
    check({tag, " stall_cnt"}, int'(stall_cnt), exp_stall);
    check({tag, " flush_cnt"}, int'(flush_cnt), exp_flush);
    check({tag, " sat stall_cnt"}, int'(s_stall_cnt), (exp_stall > 15) ? 15 : exp_stall);
    check({tag, " sat flush_cnt"}, int'(s_flush_cnt), (exp_flush > 15) ? 15 : exp_flush);
    if (!r) begin
      exp_stall = 0; exp_flush = 0;
    end else begin
      if (e[5]) exp_stall++;
      if (e[1]) exp_flush++;
    end
  endtask

  initial begin
    // reset (2 cycles), boot hold, then hazard scenarios
    v[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_IDLE);
    v[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, C_BOOT);
    for (int i = 2; i <= 5; i++) v[i] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, C_BOOT);
    v[6]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, C_IDLE);
    v[7]  = mk(1, 1, 3, 3, 1, 0, 0, 1, 1, C_LU);    // load-use on rs2
    v[8]  = mk(1, 1, 3, 3, 0, 0, 0, 1, 1, C_IDLE);  // not a load
    v[9]  = mk(1, 0, 0, 0, 1, 0, 0, 1, 1, C_IDLE);  // r0 never a hazard
    v[10] = mk(1, 5, 2, 5, 1, 0, 0, 1, 1, C_LU);    // load-use on rs1
    v[11] = mk(1, 3, 0, 3, 1, 1, 0, 0, 1, C_BR);    // branch beats load-use + imem
    v[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, C_IMEM);
    v[13] = mk(1, 0, 0, 0, 0, 0, 1, 1, 1, C_MSTRT);
    v[14] = mk(1, 0, 0, 0, 0, 1, 0, 1, 1, C_MULTI); // branch ignored in MULTI
    v[15] = mk(1, 4, 0, 4, 1, 0, 1, 0, 1, C_MULTI);
    v[16] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, C_MULTI);
    v[17] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, C_IDLE);
    v[18] = mk(1, 0, 0, 0, 0, 0, 1, 1, 1, C_MSTRT);
    v[19] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, C_MULTI); // reset in MULTI cycle 2
    for (int i = 20; i <= 23; i++) v[i] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, C_BOOT);
    v[24] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, C_IDLE);
    for (int i = 25; i <= 44; i++) v[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, C_IMEM);
    v[45] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, C_IDLE);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(v[i]);
      @(negedge clk);
      if (v[i].chk) begin
        check($sformatf("v%0d ctrl", i),
              int'({stall_f, stall_d, stall_e, flush_d, flush_e, busy}), int'(v[i].exp));
        check($sformatf("v%0d sat ctrl", i),
              int'({s_stall_f, s_stall_d, s_stall_e, s_flush_d, s_flush_e, s_busy}),
              int'(v[i].exp));
      end
      if (i >= 1) check_counters($sformatf("v%0d", i), v[i].rst, v[i].exp);
      else if (!v[i].rst) begin exp_stall = 0; exp_flush = 0; end
    end

    // Saturated counter must hold at 15 while stalls continue.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      rst = 1; mem_read_e = 0; pc_select_e = 0; mul_start_e = 0; imem_ready = 0;
      @(negedge clk);
      check($sformatf("hold%0d ctrl", k), int'({stall_f, flush_d, busy}), 3'b110);
      check_counters($sformatf("hold%0d", k), 1'b1, C_IMEM);
    end
    check("sat final", int'(s_stall_cnt), 15);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
